// File: rtl/magia_tile_pkg.sv
// Tile-level constants and types shared by the fractal-sync blocks.
// Widths here size the tree/neighbor ports and the request scheduler.
package magia_tile_pkg;

  localparam int unsigned FSYNC_AGGR_W        = 4;
  localparam int unsigned FSYNC_ID_W          = 4;
  localparam int unsigned FSYNC_NBR_AGGR_W    = 2;
  localparam int unsigned FSYNC_NBR_ID_W      = 2;
  localparam int unsigned FSYNC_SRC_W         = 2;
  localparam int unsigned FSYNC_SCHED_N_REQ   = 3;
  localparam int unsigned FSYNC_SCHED_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } fsync_sched_state_e;

  typedef enum logic [1:0] {
    HT,
    VT,
    HN,
    VN
  } fsync_port_e;

  // aggr==1 reaches neighbors via id[1]; otherwise only the tree pair
  function automatic fsync_port_e fsync_route(
    input logic       nbr,
    input logic [1:0] id
  );
    fsync_port_e p;
    p = HT;
    if (!nbr) begin
      p = id[0] ? VT : HT;
    end else begin
      unique case (id)
        2'b00:   p = HT;
        2'b01:   p = VT;
        2'b10:   p = HN;
        default: p = VN;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/fractal_sync_if.sv
// Fractal-sync barrier port: sync/aggr/id/src out, wake/error back.
// Width parameters let the same bundle serve tree and neighbor links.
interface fractal_sync_if #(
  parameter int unsigned AGGR_WIDTH = magia_tile_pkg::FSYNC_AGGR_W,
  parameter int unsigned ID_WIDTH   = magia_tile_pkg::FSYNC_ID_W,
  parameter int unsigned SRC_WIDTH  = magia_tile_pkg::FSYNC_SRC_W
);

  logic                  sync;
  logic [AGGR_WIDTH-1:0] aggr;
  logic [ID_WIDTH-1:0]   id;
  logic [SRC_WIDTH-1:0]  src;
  logic                  wake;
  logic                  error;

  modport mst_port (
    output sync, aggr, id, src,
    input  wake, error
  );

  modport slv_port (
    input  sync, aggr, id, src,
    output wake, error
  );

endinterface

// File: rtl/fractal_sync_rr_arbiter.sv
// Round-robin grant over N_REQ requesters; the pointer moves to
// one past the winner on every grant.
module fractal_sync_rr_arbiter #(
  parameter  int unsigned N_REQ = 3,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // first pass: at/after pointer; second pass wraps to the bottom
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (en_i && !vld_o && req_i[i] && (32'(ptr_q) <= i)) begin
        vld_o    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (en_i && !vld_o && req_i[i]) begin
        vld_o    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (vld_o) begin
      ptr_d = (idx_o == IDX_W'(N_REQ - 1)) ? '0 : idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fractal_sync_req_scheduler.sv
// Shares the tile fractal-sync master ports between N_REQ local
// barrier requesters; one barrier in flight, watchdog-guarded.
module fractal_sync_req_scheduler
  import magia_tile_pkg::*;
#(
  parameter int unsigned N_REQ      = FSYNC_SCHED_N_REQ,
  parameter int unsigned AGGR_W     = FSYNC_AGGR_W,
  parameter int unsigned ID_W       = FSYNC_ID_W,
  parameter int unsigned NBR_AGGR_W = FSYNC_NBR_AGGR_W,
  parameter int unsigned NBR_ID_W   = FSYNC_NBR_ID_W,
  parameter int unsigned TIMEOUT    = FSYNC_SCHED_TIMEOUT
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  output logic [N_REQ-1:0]             req_ready_o,
  input  logic [N_REQ-1:0][AGGR_W-1:0] req_aggr_i,
  input  logic [N_REQ-1:0][ID_W-1:0]   req_id_i,
  output logic [N_REQ-1:0]             rsp_valid_o,
  output logic                         rsp_error_o,
  fractal_sync_if.mst_port             ht_fsync_if_o,
  fractal_sync_if.mst_port             hn_fsync_if_o,
  fractal_sync_if.mst_port             vt_fsync_if_o,
  fractal_sync_if.mst_port             vn_fsync_if_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  fsync_sched_state_e state_q, state_d;
  fsync_port_e        sel;

  logic [IDX_W-1:0]  owner_q, gnt_idx;
  logic [AGGR_W-1:0] aggr_q;
  logic [ID_W-1:0]   id_q;
  logic              err_q, to_q;
  logic              gnt_vld, arb_en;
  logic              wake_any, err_any, to_hit;
  logic              issue, go_ht, go_vt, go_hn, go_vn;

  assign arb_en = (state_q == IDLE) && !clear_i;

  fractal_sync_rr_arbiter #(
    .N_REQ (N_REQ)
  ) i_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (arb_en),
    .req_i   (req_valid_i),
    .gnt_o   (req_ready_o),
    .idx_o   (gnt_idx),
    .vld_o   (gnt_vld)
  );

  assign wake_any = ht_fsync_if_o.wake | hn_fsync_if_o.wake |
                    vt_fsync_if_o.wake | vn_fsync_if_o.wake;
  assign err_any  = ht_fsync_if_o.error | hn_fsync_if_o.error |
                    vt_fsync_if_o.error | vn_fsync_if_o.error;

  if (TIMEOUT > 0) begin : g_wd
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                          cnt_q <= '0;
      else if (clear_i || state_q != WAIT)  cnt_q <= '0;
      else                                  cnt_q <= cnt_q + CNT_W'(1);
    end

    assign to_hit = (state_q == WAIT) && !wake_any &&
                    (cnt_q == CNT_W'(TIMEOUT - 1));
  end else begin : g_no_wd
    assign to_hit = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (gnt_vld) state_d = ISSUE;
        ISSUE:   state_d = (wake_any || err_any) ? RESP : WAIT;
        WAIT:    if (wake_any || err_any || to_hit) state_d = RESP;
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q <= '0;
      aggr_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      if (gnt_vld) begin
        owner_q <= gnt_idx;
        aggr_q  <= req_aggr_i[gnt_idx];
        id_q    <= req_id_i[gnt_idx];
        err_q   <= 1'b0;
      end else if (state_q == ISSUE || state_q == WAIT) begin
        err_q   <= err_q | err_any | to_hit;
      end
      if (clear_i)     to_q <= 1'b0;
      else if (to_hit) to_q <= 1'b1;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESP) rsp_valid_o[owner_q] = 1'b1;
    rsp_error_o = (state_q == RESP) && err_q;
    busy_o      = (state_q != IDLE);
    timeout_o   = to_q;
  end

  assign sel   = fsync_route(aggr_q == AGGR_W'(1), id_q[1:0]);
  assign issue = (state_q == ISSUE);
  assign go_ht = issue && (sel == HT);
  assign go_vt = issue && (sel == VT);
  assign go_hn = issue && (sel == HN);
  assign go_vn = issue && (sel == VN);

  assign ht_fsync_if_o.sync = go_ht;
  assign ht_fsync_if_o.aggr = go_ht ? aggr_q : '0;
  assign ht_fsync_if_o.id   = go_ht ? id_q : '0;
  assign ht_fsync_if_o.src  = '0;

  assign vt_fsync_if_o.sync = go_vt;
  assign vt_fsync_if_o.aggr = go_vt ? aggr_q : '0;
  assign vt_fsync_if_o.id   = go_vt ? id_q : '0;
  assign vt_fsync_if_o.src  = '0;

  assign hn_fsync_if_o.sync = go_hn;
  assign hn_fsync_if_o.aggr = go_hn ? aggr_q[NBR_AGGR_W-1:0] : '0;
  assign hn_fsync_if_o.id   = go_hn ? id_q[NBR_ID_W-1:0] : '0;
  assign hn_fsync_if_o.src  = '0;

  assign vn_fsync_if_o.sync = go_vn;
  assign vn_fsync_if_o.aggr = go_vn ? aggr_q[NBR_AGGR_W-1:0] : '0;
  assign vn_fsync_if_o.id   = go_vn ? id_q[NBR_ID_W-1:0] : '0;
  assign vn_fsync_if_o.src  = '0;

endmodule

// File: doc/fractal_sync_req_scheduler.md
# fractal_sync_req_scheduler

Shares one tile-level fractal-sync master port set between `N_REQ` local barrier requesters, such as the core Xif decoder, the iDMA controller and the accelerator controller. A round-robin arbiter picks one requester, and that requester's barrier is issued to the horizontal/vertical tree or neighbor port selected by its `aggr`/`id`. The block then waits for `wake` or `error`, guarded by a watchdog, and returns a one-cycle response to the owning requester. One barrier is outstanding at a time. The block sits in the tile between the requesters and the four `fractal_sync_if` master ports.

## Interface
Parameters:
- `N_REQ`, default `magia_tile_pkg::FSYNC_SCHED_N_REQ` (3): number of requesters, ≥1.
- `AGGR_W`, default `magia_tile_pkg::FSYNC_AGGR_W`: aggregation field width.
- `ID_W`, default `magia_tile_pkg::FSYNC_ID_W`: barrier id width, ≥2.
- `NBR_AGGR_W`, default `magia_tile_pkg::FSYNC_NBR_AGGR_W`: neighbor aggregation width.
- `NBR_ID_W`, default `magia_tile_pkg::FSYNC_NBR_ID_W`: neighbor id width.
- `TIMEOUT`, default `magia_tile_pkg::FSYNC_SCHED_TIMEOUT` (1024): watchdog cycles in WAIT; 0 disables the watchdog.

Ports (clock and reset first):
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  asynchronous active-low reset.
- `clear_i`  in  1  synchronous soft clear.
- `req_valid_i`  in  `N_REQ`  barrier request valid, one bit per requester.
- `req_ready_o`  out  `N_REQ`  request accepted; one-hot or zero.
- `req_aggr_i`  in  `N_REQ`×`AGGR_W`  per-requester aggregation.
- `req_id_i`  in  `N_REQ`×`ID_W`  per-requester barrier id.
- `rsp_valid_o`  out  `N_REQ`  one-cycle completion pulse, one-hot or zero.
- `rsp_error_o`  out  1  error qualifier, valid with `rsp_valid_o`.
- `ht_fsync_if_o`, `hn_fsync_if_o`, `vt_fsync_if_o`, `vn_fsync_if_o`: `fractal_sync_if.mst_port` master ports.
- `busy_o`  out  1  high while not in IDLE.
- `timeout_o`  out  1  sticky watchdog flag.

Reset values: all outputs 0; all `fsync` `sync`/`aggr`/`id`/`src` at 0; FSM in IDLE; RR pointer 0; watchdog counter 0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Grant goes to the lowest index ≥ RR pointer (wrapping) with `req_valid_i` set.
  - The granted requester's `req_ready_o` is high combinationally in the same cycle.
  - On the handshake: latch `aggr`, `id` and the owner index; set the pointer to owner+1 mod `N_REQ`; go to ISSUE.
- **ISSUE:** drive exactly one port for one cycle with `sync=1`. Port routing:
  - `aggr≠1`: `id[0]=0` selects ht, `id[0]=1` selects vt.
  - `aggr==1`: `id[1:0]` of 00/01/10/11 selects ht/vt/hn/vn respectively.
  - Tree ports take `aggr[AGGR_W-1:0]`/`id[ID_W-1:0]`; neighbor ports take the `NBR_*` slices.
  - `src` is always 0.
  - Next state is WAIT, or RESP if `wake` or `error` is seen this cycle.
- **WAIT:**
  - OR the four `wake` bits and the four `error` bits; the watchdog counter increments each cycle.
  - Go to RESP on wake or error.
  - Go to RESP with the error flag if the counter reaches `TIMEOUT-1` without wake; this also sets `timeout_o`.
- **RESP:**
  - Pulse `rsp_valid_o[owner]` for one cycle; `rsp_error_o` = latched error or timeout.
  - Reset the counter; go to IDLE. There is no back-pressure on the response.
- Wake and error in the same cycle gives a response with `rsp_error_o=1`.
- `wake`/`error` arriving in IDLE or RESP is ignored.
- Requesters hold `valid`, `aggr` and `id` stable until ready. A requester does not re-request before its own response.
- `clear_i` in any state: next state IDLE, pointer 0, counter 0, `timeout_o` cleared. The in-flight barrier is dropped with no response, and there is no grant in that cycle.
- Reset mid-operation behaves the same as `clear_i`, but asynchronously.

## Timing
- Request accepted at cycle t: `sync` is high in t+1 only.
- Earliest wake is t+1. If wake arrives at cycle w, `rsp_valid_o` is high at w+1 and the next grant is possible at w+2.
- Back-to-back throughput is one barrier per 3 + tree-latency cycles.
- Timeout: with `sync` at t+1, WAIT starts at t+2 and the error response appears at t+2+`TIMEOUT`.
- Grant, `req_ready_o` and routing are combinational from registered state and inputs. All other outputs are registered-state decodes.

## Structure
- `magia_tile_pkg` additions:
  - `FSYNC_SCHED_N_REQ` and `FSYNC_SCHED_TIMEOUT`.
  - Enum `fsync_sched_state_e` with values IDLE/ISSUE/WAIT/RESP.
  - Port-select enum `fsync_port_e` with values HT/VT/HN/VN.
- Sub-module `fractal_sync_rr_arbiter`: combinational round-robin grant over `N_REQ` plus the registered pointer.
- The watchdog counter width is `$clog2(TIMEOUT+1)`; with `TIMEOUT`=0 the counter logic is removed.

## Test plan
- Requester 0 sends `aggr=4`, `id=6`; tree wake arrives 5 cycles after `sync`. Required: `ht` `sync` pulse with `aggr=4`/`id=6`, then `rsp_valid_o=001` and `rsp_error_o=0` one cycle after wake.
- `aggr=1`, cycling `id` through 0..3. Required: `sync` on ht, vt, hn, vn respectively with `NBR` slices; the other three ports stay at 0.
- All three requesters valid from reset. Required: grants in order 0,1,2,0; each `rsp_valid_o` goes to the correct owner.
- `TIMEOUT=8`, no wake. Required: `rsp_error_o=1` at `sync`+9, `timeout_o` stays high until `clear_i`, and the next request still issues.
- `vt` `error` raised in WAIT together with `wake`. Required: single response with `rsp_error_o=1`.
- `clear_i` in WAIT, and `rst_ni` low in ISSUE. Required: no `rsp_valid_o`; IDLE the next cycle; the pointer restarts at requester 0.
